// File: rtl/c1541_pkg.sv
// Shared types and D64 geometry helpers for the 1541 track loader.
// Zone tables map a 1-based track to its sector count and image offset.
package c1541_pkg;

  localparam int MAX_SECTORS = 21;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH_SCAN,
    S_FLUSH_XFER,
    S_LOAD_REQ,
    S_LOAD_XFER
  } state_e;

  function automatic logic [4:0] spt(input logic [5:0] t);
    logic [4:0] n;
    unique case (1'b1)
      (t < 6'd18): n = 5'd21;
      (t >= 6'd18 && t < 6'd25): n = 5'd19;
      (t >= 6'd25 && t < 6'd31): n = 5'd18;
      default: n = 5'd17;
    endcase
    return n;
  endfunction

  function automatic logic [9:0] track_base(input logic [5:0] t);
    logic [9:0] tw;
    logic [9:0] b;
    tw = {4'd0, t};
    unique case (1'b1)
      (t < 6'd18):
        b = (tw - 10'd1) * 10'd21;
      (t >= 6'd18 && t < 6'd25):
        b = 10'd357 + (tw - 10'd18) * 10'd19;
      (t >= 6'd25 && t < 6'd31):
        b = 10'd490 + (tw - 10'd25) * 10'd18;
      default:
        b = 10'd598 + (tw - 10'd31) * 10'd17;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/c1541_dirty_scan.sv
// Lowest-set-bit finder over the dirty sector mask.
// Bits at or above the track's sector count are ignored.
module c1541_dirty_scan
  import c1541_pkg::*;
(
  input  logic [MAX_SECTORS-1:0] dirty,
  input  logic [4:0]             limit,
  output logic [4:0]             sector,
  output logic                   valid
);

  always_comb begin
    sector = 5'd0;
    valid  = 1'b0;
    // walk downwards so the lowest hit is the last assignment
    for (int i = MAX_SECTORS - 1; i >= 0; i--) begin
      if (dirty[i] && (5'(i) < limit)) begin
        sector = 5'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/c1541_track_loader.sv
// Moves one D64 track between the SD block interface and the track RAM,
// flushing GCR-dirtied sectors back to the image before a new load.
module c1541_track_loader
  import c1541_pkg::*;
#(
  parameter int MAX_TRACK = 35
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic [5:0]  track,
  input  logic        img_mounted,
  input  logic        img_size_nz,
  input  logic        gcr_we,
  input  logic [4:0]  gcr_sector,
  output logic        ram_ready,
  output logic [12:0] buff_addr,
  output logic [7:0]  buff_di,
  output logic        buff_we,
  input  logic [7:0]  buff_do,
  output logic [9:0]  sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din
);

  localparam logic [5:0] MaxTrk = 6'(MAX_TRACK);

  state_e state_q, state_d;

  logic [5:0] cur_track_q, cur_track_d;
  logic [5:0] new_track_q, new_track_d;
  logic [MAX_SECTORS-1:0] dirty_q, dirty_d;
  logic disk_present_q, disk_present_d;
  logic mount_pend_q, mount_pend_d;
  logic mount_nz_q, mount_nz_d;
  logic [4:0] sector_q, sector_d;
  logic ack_q, ack_d;

  logic ram_ready_q, ram_ready_d;
  logic sd_rd_q, sd_rd_d;
  logic sd_wr_q, sd_wr_d;
  logic buff_we_q, buff_we_d;
  logic [9:0] sd_lba_q, sd_lba_d;
  logic [12:0] buff_addr_q, buff_addr_d;
  logic [7:0] buff_di_q, buff_di_d;
  logic [7:0] sd_buff_din_q, sd_buff_din_d;

  logic track_ok;
  logic ack_fall;
  logic [4:0] cur_spt;
  logic [4:0] new_spt;
  logic [4:0] scan_sector;
  logic scan_valid;

  assign track_ok = (track != 6'd0) && (track <= MaxTrk);
  assign ack_fall = ack_q && !sd_ack;
  assign cur_spt  = spt(cur_track_q);
  assign new_spt  = spt(new_track_q);

  c1541_dirty_scan u_scan (
    .dirty  (dirty_q),
    .limit  (cur_spt),
    .sector (scan_sector),
    .valid  (scan_valid)
  );

  always_comb begin
    state_d        = state_q;
    cur_track_d    = cur_track_q;
    new_track_d    = new_track_q;
    dirty_d        = dirty_q;
    disk_present_d = disk_present_q;
    mount_pend_d   = mount_pend_q;
    mount_nz_d     = mount_nz_q;
    sector_d       = sector_q;
    ack_d          = sd_ack;
    ram_ready_d    = ram_ready_q;
    sd_rd_d        = sd_rd_q;
    sd_wr_d        = sd_wr_q;
    buff_we_d      = 1'b0;
    sd_lba_d       = sd_lba_q;
    buff_addr_d    = buff_addr_q;
    buff_di_d      = buff_di_q;
    sd_buff_din_d  = sd_buff_din_q;

    if (gcr_we && ram_ready_q &&
        (gcr_sector < 5'(MAX_SECTORS))) begin
      dirty_d[gcr_sector] = 1'b1;
    end

    // a mount seen mid-transfer waits for IDLE
    if (img_mounted) begin
      mount_pend_d = 1'b1;
      mount_nz_d   = img_size_nz;
    end

    case (state_q)
      S_IDLE: begin
        if (mount_pend_q || img_mounted) begin
          disk_present_d = img_mounted ? img_size_nz
                                       : mount_nz_q;
          mount_pend_d   = 1'b0;
          cur_track_d    = 6'd0;
          dirty_d        = '0;
          ram_ready_d    = 1'b0;
        end else if (disk_present_q && track_ok &&
                     (track != cur_track_q)) begin
          ram_ready_d = 1'b0;
          new_track_d = track;
          state_d     = S_FLUSH_SCAN;
        end else begin
          ram_ready_d = (cur_track_q != 6'd0);
        end
      end

      S_FLUSH_SCAN: begin
        if (cur_track_q != 6'd0 && scan_valid) begin
          sector_d = scan_sector;
          sd_lba_d = track_base(cur_track_q)
                     + {5'd0, scan_sector};
          sd_wr_d  = 1'b1;
          state_d  = S_FLUSH_XFER;
        end else begin
          sector_d = 5'd0;
          state_d  = S_LOAD_REQ;
        end
      end

      S_FLUSH_XFER: begin
        sd_buff_din_d = buff_do;
        if (sd_ack) begin
          sd_wr_d = 1'b0;
        end
        if (ack_fall) begin
          dirty_d[sector_q] = 1'b0;
          state_d = S_FLUSH_SCAN;
        end
      end

      S_LOAD_REQ: begin
        sd_lba_d = track_base(new_track_q)
                   + {5'd0, sector_q};
        sd_rd_d  = 1'b1;
        state_d  = S_LOAD_XFER;
      end

      S_LOAD_XFER: begin
        if (sd_ack) begin
          sd_rd_d = 1'b0;
        end
        if (sd_buff_wr) begin
          buff_we_d   = 1'b1;
          buff_addr_d = {sector_q, sd_buff_addr};
          buff_di_d   = sd_buff_dout;
        end
        if (ack_fall) begin
          if (sector_q == new_spt - 5'd1) begin
            cur_track_d = new_track_q;
            dirty_d     = '0;
            state_d     = S_IDLE;
          end else begin
            sector_d = sector_q + 5'd1;
            state_d  = S_LOAD_REQ;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cur_track_q    <= 6'd0;
      new_track_q    <= 6'd0;
      dirty_q        <= '0;
      disk_present_q <= 1'b0;
      mount_pend_q   <= 1'b0;
      mount_nz_q     <= 1'b0;
      sector_q       <= 5'd0;
      ack_q          <= 1'b0;
      ram_ready_q    <= 1'b0;
      sd_rd_q        <= 1'b0;
      sd_wr_q        <= 1'b0;
      buff_we_q      <= 1'b0;
      sd_lba_q       <= 10'd0;
      buff_addr_q    <= 13'd0;
      buff_di_q      <= 8'd0;
      sd_buff_din_q  <= 8'd0;
    end else begin
      state_q        <= state_d;
      cur_track_q    <= cur_track_d;
      new_track_q    <= new_track_d;
      dirty_q        <= dirty_d;
      disk_present_q <= disk_present_d;
      mount_pend_q   <= mount_pend_d;
      mount_nz_q     <= mount_nz_d;
      sector_q       <= sector_d;
      ack_q          <= ack_d;
      ram_ready_q    <= ram_ready_d;
      sd_rd_q        <= sd_rd_d;
      sd_wr_q        <= sd_wr_d;
      buff_we_q      <= buff_we_d;
      sd_lba_q       <= sd_lba_d;
      buff_addr_q    <= buff_addr_d;
      buff_di_q      <= buff_di_d;
      sd_buff_din_q  <= sd_buff_din_d;
    end
  end

  // flush reads follow the host address with no extra register stage
  assign buff_addr   = (state_q == S_FLUSH_XFER)
                       ? {sector_q, sd_buff_addr}
                       : buff_addr_q;
  assign ram_ready   = ram_ready_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign buff_we     = buff_we_q;
  assign sd_lba      = sd_lba_q;
  assign buff_di     = buff_di_q;
  assign sd_buff_din = sd_buff_din_q;

endmodule

// File: tb/tb_c1541_track_loader.sv
// Directed bench: host SD model plus a 1-cycle track RAM on port B.
`timescale 1ns/1ps
module tb_c1541_track_loader;

  logic        clk32 = 1'b0;
  logic        reset;
  logic [5:0]  track;
  logic        img_mounted, img_size_nz;
  logic        gcr_we;
  logic [4:0]  gcr_sector;
  logic        ram_ready;
  logic [12:0] buff_addr;
  logic [7:0]  buff_di, buff_do;
  logic        buff_we;
  logic [9:0]  sd_lba;
  logic        sd_rd, sd_wr, sd_ack;
  logic [7:0]  sd_buff_addr, sd_buff_dout, sd_buff_din;
  logic        sd_buff_wr;

  int checks = 0;
  int failures = 0;

  int          log_lba [64];
  logic        log_wr  [64];
  logic        log_rdy [64];
  logic [7:0]  log_b0  [64];
  logic [7:0]  log_b1  [64];

  logic [7:0] mem [0:8191];

  always #16 clk32 = ~clk32;

  c1541_track_loader #(.MAX_TRACK(35)) dut (
    .clk32        (clk32),
    .reset        (reset),
    .track        (track),
    .img_mounted  (img_mounted),
    .img_size_nz  (img_size_nz),
    .gcr_we       (gcr_we),
    .gcr_sector   (gcr_sector),
    .ram_ready    (ram_ready),
    .buff_addr    (buff_addr),
    .buff_di      (buff_di),
    .buff_we      (buff_we),
    .buff_do      (buff_do),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din)
  );

  always @(posedge clk32) begin
    if (buff_we) mem[buff_addr] <= buff_di;
    buff_do <= mem[buff_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] hdata(input int lba, input int off);
    return 8'((lba * 7 + off * 3 + 1) & 255);
  endfunction

  task automatic mount(input logic nz);
    @(negedge clk32);
    img_size_nz = nz;
    img_mounted = 1'b1;
    @(negedge clk32);
    img_mounted = 1'b0;
  endtask

  // Serves up to n blocks; hook kind 1 changes track, kind 2 pulses gcr_we.
  task automatic serve_blocks(input int n, input int hk_idx,
                              input int hk_kind, input int hk_val,
                              output int got);
    int w;
    int off;
    got = 0;
    for (int b = 0; b < n; b++) begin
      w = 0;
      while (!(sd_rd || sd_wr) && w < 300) begin
        @(negedge clk32);
        w++;
      end
      if (!(sd_rd || sd_wr)) break;
      log_lba[b] = int'(sd_lba);
      log_wr[b]  = sd_wr;
      log_rdy[b] = ram_ready;
      sd_ack = 1'b1;
      @(negedge clk32);
      if (b == hk_idx && hk_kind == 1) track = 6'(hk_val);
      if (b == hk_idx && hk_kind == 2) begin
        gcr_sector = 5'(hk_val);
        gcr_we = 1'b1;
        @(negedge clk32);
        gcr_we = 1'b0;
      end
      if (log_wr[b]) begin
        sd_buff_addr = 8'h00;
        repeat (3) @(negedge clk32);
        log_b0[b] = sd_buff_din;
        sd_buff_addr = 8'h10;
        repeat (3) @(negedge clk32);
        log_b1[b] = sd_buff_din;
      end else begin
        for (int k = 0; k < 3; k++) begin
          off = (k == 0) ? 0 : (k == 1) ? 16 : 255;
          sd_buff_addr = 8'(off);
          sd_buff_dout = hdata(log_lba[b], off);
          sd_buff_wr = 1'b1;
          @(negedge clk32);
          sd_buff_wr = 1'b0;
          @(negedge clk32);
        end
      end
      sd_ack = 1'b0;
      @(negedge clk32);
      got++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    track = 6'd0; img_mounted = 0; img_size_nz = 0;
    gcr_we = 0; gcr_sector = 0; sd_ack = 0;
    sd_buff_addr = 0; sd_buff_dout = 0; sd_buff_wr = 0;
    repeat (3) @(negedge clk32);
    checks++;
    if ({ram_ready, sd_rd, sd_wr, buff_we} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0000",
               {ram_ready, sd_rd, sd_wr, buff_we});
    end
    checks++;
    if ({sd_lba, buff_addr, buff_di, sd_buff_din} !== 39'd0) begin
      failures++;
      $display("FAIL reset_data: lba=%0d addr=%0h di=%0h din=%0h want 0",
               sd_lba, buff_addr, buff_di, sd_buff_din);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk32);
  endtask

  task automatic test_mount_track1;
    int got;
    int bad;
    track = 6'd1;
    mount(1'b1);
    serve_blocks(21, -1, 0, 0, got);
    checks++;
    if (got !== 21) begin
      failures++;
      $display("FAIL t1_blocks: got %0d want 21", got);
    end
    bad = 0;
    for (int i = 0; i < got; i++)
      if (log_lba[i] != i || log_wr[i] !== 1'b0 || log_rdy[i] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL t1_lba_seq: %0d bad blocks want 0", bad);
    end
    repeat (5) @(negedge clk32);
    checks++;
    if (ram_ready !== 1'b1 || sd_rd !== 1'b0) begin
      failures++;
      $display("FAIL t1_ready: ram_ready=%b sd_rd=%b want 1 0",
               ram_ready, sd_rd);
    end
    checks++;
    if (mem[{5'd5, 8'h10}] !== hdata(5, 16)) begin
      failures++;
      $display("FAIL t1_byte_5_10: got %0h want %0h",
               mem[{5'd5, 8'h10}], hdata(5, 16));
    end
    checks++;
    if (mem[{5'd20, 8'hFF}] !== hdata(20, 255)) begin
      failures++;
      $display("FAIL t1_byte_20_ff: got %0h want %0h",
               mem[{5'd20, 8'hFF}], hdata(20, 255));
    end
  endtask

  task automatic test_dirty_flush;
    int got;
    int bad;
    @(negedge clk32);
    gcr_sector = 5'd3; gcr_we = 1'b1;
    @(negedge clk32);
    gcr_sector = 5'd7;
    @(negedge clk32);
    gcr_we = 1'b0;
    track = 6'd2;
    // sector 9 written while ram_ready is low must not be flushed
    serve_blocks(23, 0, 2, 9, got);
    checks++;
    if (got !== 23) begin
      failures++;
      $display("FAIL flush_blocks: got %0d want 23", got);
    end
    checks++;
    if (log_wr[0] !== 1'b1 || log_lba[0] != 3 ||
        log_wr[1] !== 1'b1 || log_lba[1] != 7) begin
      failures++;
      $display("FAIL flush_lbas: wr=%b%b lba=%0d,%0d want 11 3,7",
               log_wr[0], log_wr[1], log_lba[0], log_lba[1]);
    end
    checks++;
    if (log_b0[0] !== hdata(3, 0) || log_b1[0] !== hdata(3, 16)) begin
      failures++;
      $display("FAIL flush_data3: got %0h %0h want %0h %0h",
               log_b0[0], log_b1[0], hdata(3, 0), hdata(3, 16));
    end
    checks++;
    if (log_b0[1] !== hdata(7, 0) || log_b1[1] !== hdata(7, 16)) begin
      failures++;
      $display("FAIL flush_data7: got %0h %0h want %0h %0h",
               log_b0[1], log_b1[1], hdata(7, 0), hdata(7, 16));
    end
    bad = 0;
    for (int i = 2; i < got; i++)
      if (log_lba[i] != 21 + i - 2 || log_wr[i] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL t2_lba_seq: %0d bad blocks want 0", bad);
    end
    repeat (20) @(negedge clk32);
    checks++;
    if (ram_ready !== 1'b1 || sd_wr !== 1'b0 || sd_rd !== 1'b0) begin
      failures++;
      $display("FAIL t2_idle: rdy=%b wr=%b rd=%b want 1 0 0",
               ram_ready, sd_wr, sd_rd);
    end
  endtask

  task automatic test_zones;
    int got;
    track = 6'd18;
    serve_blocks(19, -1, 0, 0, got);
    checks++;
    if (got !== 19 || log_lba[0] != 357 || log_lba[18] != 375) begin
      failures++;
      $display("FAIL t18: blocks=%0d first=%0d last=%0d want 19 357 375",
               got, log_lba[0], log_lba[18]);
    end
    repeat (5) @(negedge clk32);
    track = 6'd31;
    serve_blocks(17, -1, 0, 0, got);
    checks++;
    if (got !== 17 || log_lba[0] != 598 || log_lba[16] != 614) begin
      failures++;
      $display("FAIL t31: blocks=%0d first=%0d last=%0d want 17 598 614",
               got, log_lba[0], log_lba[16]);
    end
    repeat (20) @(negedge clk32);
    checks++;
    if (ram_ready !== 1'b1 || sd_rd !== 1'b0) begin
      failures++;
      $display("FAIL t31_done: rdy=%b rd=%b want 1 0", ram_ready, sd_rd);
    end
  endtask

  task automatic test_change_during_load;
    int got;
    int bad;
    track = 6'd1;
    serve_blocks(21, -1, 0, 0, got);
    repeat (5) @(negedge clk32);
    track = 6'd2;
    serve_blocks(42, 3, 1, 3, got);
    checks++;
    if (got !== 42) begin
      failures++;
      $display("FAIL chg_blocks: got %0d want 42", got);
    end
    bad = 0;
    for (int i = 0; i < got; i++)
      if (log_lba[i] != 21 + i || log_wr[i] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL chg_lba_seq: %0d bad blocks want 0", bad);
    end
    bad = 0;
    for (int i = 0; i < got; i++)
      if (log_rdy[i] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL chg_ready_early: %0d blocks saw ready want 0", bad);
    end
    repeat (20) @(negedge clk32);
    checks++;
    if (ram_ready !== 1'b1 || sd_rd !== 1'b0) begin
      failures++;
      $display("FAIL chg_done: rdy=%b rd=%b want 1 0", ram_ready, sd_rd);
    end
  endtask

  task automatic test_invalid_track;
    track = 6'd0;
    mount(1'b1);
    repeat (30) @(negedge clk32);
    checks++;
    if (sd_rd !== 1'b0 || sd_wr !== 1'b0 || ram_ready !== 1'b0) begin
      failures++;
      $display("FAIL trk0: rd=%b wr=%b rdy=%b want 0 0 0",
               sd_rd, sd_wr, ram_ready);
    end
    track = 6'd36;
    repeat (30) @(negedge clk32);
    checks++;
    if (sd_rd !== 1'b0 || sd_wr !== 1'b0 || ram_ready !== 1'b0) begin
      failures++;
      $display("FAIL trk36: rd=%b wr=%b rdy=%b want 0 0 0",
               sd_rd, sd_wr, ram_ready);
    end
  endtask

  task automatic test_reset_mid_load;
    int got;
    int w;
    int bad;
    track = 6'd5;
    serve_blocks(2, -1, 0, 0, got);
    checks++;
    if (got !== 2 || log_lba[0] != 84 || log_lba[1] != 85) begin
      failures++;
      $display("FAIL t5_start: blocks=%0d lba=%0d,%0d want 2 84,85",
               got, log_lba[0], log_lba[1]);
    end
    w = 0;
    while (!sd_rd && w < 300) begin
      @(negedge clk32);
      w++;
    end
    sd_ack = 1'b1;
    @(negedge clk32);
    sd_buff_addr = 8'h00; sd_buff_dout = 8'hAA; sd_buff_wr = 1'b1;
    @(negedge clk32);
    sd_buff_wr = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (sd_rd !== 1'b0 || ram_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: rd=%b rdy=%b want 0 0", sd_rd, ram_ready);
    end
    sd_ack = 1'b0;
    repeat (2) @(negedge clk32);
    reset = 1'b0;
    mount(1'b1);
    serve_blocks(21, -1, 0, 0, got);
    bad = 0;
    for (int i = 0; i < got; i++)
      if (log_lba[i] != 84 + i) bad++;
    checks++;
    if (got !== 21 || bad != 0) begin
      failures++;
      $display("FAIL t5_reload: blocks=%0d bad=%0d want 21 0", got, bad);
    end
    repeat (5) @(negedge clk32);
    checks++;
    if (ram_ready !== 1'b1) begin
      failures++;
      $display("FAIL t5_ready: got %b want 1", ram_ready);
    end
  endtask

  initial begin
    test_reset;
    test_mount_track1;
    test_dirty_flush;
    test_zones;
    test_change_during_load;
    test_invalid_track;
    test_reset_mid_load;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
